soc_system_play_ctrl: RTL and testbench

SOC_SYSTEM_PLAY_CTRL -- requirements
Module: soc_system_play_ctrl

---
 rtl/soc_system_play_ctrl_pkg.sv | 29 ++
 rtl/soc_system_play_ctrl_fifo.sv | 51 +++++
 rtl/soc_system_play_ctrl.sv | 135 +++++++++++++
 tb/tb_soc_system_play_ctrl.sv | 363 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/soc_system_play_ctrl_pkg.sv
// Shared types and constants for the audio playback controller:
// FSM states, register map, CONTROL bit positions and FIFO geometry.
package soc_system_play_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } play_state_e;

    localparam logic [1:0] ADDR_CONTROL = 2'd0;
    localparam logic [1:0] ADDR_LENGTH  = 2'd1;
    localparam logic [1:0] ADDR_STATUS  = 2'd2;
    localparam logic [1:0] ADDR_FIFO    = 2'd3;

    localparam int CTRL_PLAY   = 0;
    localparam int CTRL_PAUSE  = 1;
    localparam int CTRL_STOP   = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int FIFO_DEPTH = 8;
    localparam int LEVEL_W    = 4;
    localparam int PTR_W      = 3;
    localparam int DATA_W     = 32;
    localparam int LENGTH_W   = 24;
    localparam int UNDERRUN_W = 16;

endpackage

// File: rtl/soc_system_play_ctrl_fifo.sv
// 8 x 32 sample FIFO with flush; a push into a full FIFO succeeds only
// when a pop happens in the same cycle.
module soc_system_play_ctrl_fifo
    import soc_system_play_ctrl_pkg::*;
(
    input  logic               clk,
    input  logic               reset_n,
    input  logic               push,
    input  logic               pop,
    input  logic               flush,
    input  logic [DATA_W-1:0]  wdata,
    output logic [DATA_W-1:0]  rdata,
    output logic               full,
    output logic               empty,
    output logic [LEVEL_W-1:0] level
);

    logic [DATA_W-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic              do_push;
    logic              do_pop;

    assign full    = (level == LEVEL_W'(FIFO_DEPTH));
    assign empty   = (level == '0);
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);
    assign rdata   = mem[rd_ptr];

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            level <= level + LEVEL_W'(do_push) - LEVEL_W'(do_pop);
        end
    end

    // NOTE: storage has no reset; pointers and level alone decide which entries are valid.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= wdata;
    end

endmodule

// File: rtl/soc_system_play_ctrl.sv
// Avalon-MM audio playback controller: register file, play/pause/done FSM,
// sample pacing from sample_tick and completion interrupt.
module soc_system_play_ctrl
    import soc_system_play_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic [1:0]  address,
    input  logic        chipselect,
    input  logic        write_n,
    input  logic [31:0] writedata,
    output logic [31:0] readdata,
    input  logic        sample_tick,
    output logic [31:0] sample_data,
    output logic        sample_valid,
    output logic        playing,
    output logic        irq
);

    play_state_e           state_q, state_d;
    logic [LENGTH_W-1:0]   length_q;
    logic [LENGTH_W-1:0]   played_q;
    logic [LENGTH_W-1:0]   played_inc;
    logic [UNDERRUN_W-1:0] underrun_q;
    logic                  overflow_q, pause_q, irq_en_q, irq_q;
    logic                  wr_en, ctrl_wr, stop_req, start, push, push_drop;
    logic                  tick_play, pop, underrun, done_hit;
    logic [DATA_W-1:0]     fifo_head;
    logic                  fifo_full, fifo_empty;
    logic [LEVEL_W-1:0]    fifo_level;

    assign wr_en      = chipselect && !write_n;
    assign ctrl_wr    = wr_en && (address == ADDR_CONTROL);
    assign stop_req   = ctrl_wr && writedata[CTRL_STOP];
    assign push       = wr_en && (address == ADDR_FIFO);
    assign tick_play  = sample_tick && (state_q == ST_PLAY);
    assign pop        = tick_play && !fifo_empty;
    assign underrun   = tick_play && fifo_empty;
    assign played_inc = played_q + 1'b1;
    assign done_hit   = pop && (played_inc == length_q);
    assign start      = ctrl_wr && !stop_req && (state_q == ST_IDLE) &&
                        writedata[CTRL_PLAY] && (length_q != '0);
    assign push_drop  = push && fifo_full && !pop && !stop_req;

    soc_system_play_ctrl_fifo u_fifo (
        .clk     (clk),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .flush   (stop_req),
        .wdata   (writedata),
        .rdata   (fifo_head),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .level   (fifo_level)
    );

    // Ticks act on the pre-write state, so completion outranks a same-cycle pause.
    always_comb begin
        // NOTE: default first so every path assigns state_d and no latch is inferred.
        state_d = state_q;
        if (stop_req) begin
            state_d = ST_IDLE;
        end else if (done_hit) begin
            state_d = ST_DONE;
        end else if (ctrl_wr) begin
            case (state_q)
                ST_IDLE:  if (start) state_d = ST_PLAY;
                ST_PLAY:  if (writedata[CTRL_PAUSE]) state_d = ST_PAUSE;
                ST_PAUSE: if (!writedata[CTRL_PAUSE]) state_d = ST_PLAY;
                ST_DONE:  state_d = ST_IDLE;
                default:  state_d = ST_IDLE;
            endcase
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            length_q     <= '0;
            played_q     <= '0;
            underrun_q   <= '0;
            overflow_q   <= 1'b0;
            pause_q      <= 1'b0;
            irq_en_q     <= 1'b0;
            irq_q        <= 1'b0;
            sample_data  <= '0;
            sample_valid <= 1'b0;
        end else begin
            sample_valid <= tick_play;
            if (tick_play) sample_data <= pop ? fifo_head : '0;

            if (wr_en && (address == ADDR_LENGTH) && (state_q == ST_IDLE))
                length_q <= writedata[LENGTH_W-1:0];

            if (ctrl_wr) begin
                pause_q  <= writedata[CTRL_PAUSE];
                irq_en_q <= writedata[CTRL_IRQ_EN];
            end

            if (stop_req || start) played_q <= '0;
            else if (pop)          played_q <= played_inc;

            if (stop_req)                         underrun_q <= '0;
            else if (underrun && underrun_q != '1) underrun_q <= underrun_q + 1'b1;

            if (stop_req)       overflow_q <= 1'b0;
            else if (push_drop) overflow_q <= 1'b1;

            if (stop_req || (ctrl_wr && state_q == ST_DONE)) irq_q <= 1'b0;
            else if (done_hit && irq_en_q)                   irq_q <= 1'b1;
        end
    end

    assign playing = (state_q == ST_PLAY);
    assign irq     = irq_q && irq_en_q;

    always_comb begin
        readdata = '0;
        case (address)
            ADDR_CONTROL: readdata = {30'd0, irq_en_q, pause_q};
            ADDR_LENGTH:  readdata = {8'd0, length_q};
            ADDR_STATUS:  readdata = {underrun_q, 7'd0, overflow_q, fifo_level,
                                      fifo_full, fifo_empty, state_q};
            ADDR_FIFO:    readdata = {8'd0, played_q};
            default:      readdata = '0;
        endcase
    end

endmodule

// File: tb/tb_soc_system_play_ctrl.sv
// Testbench for soc_system_play_ctrl: directed scenarios plus a randomized run
// compared against a queue-based behavioural model of the controller.
module tb_soc_system_play_ctrl;

    logic        clk = 1'b0;
    logic        reset_n;
    logic [1:0]  address;
    logic        chipselect;
    logic        write_n;
    logic [31:0] writedata;
    logic [31:0] readdata;
    logic        sample_tick;
    logic [31:0] sample_data;
    logic        sample_valid;
    logic        playing;
    logic        irq;

    int checks   = 0;
    int failures = 0;

    // Behavioural model: state as a number, FIFO as a queue.
    int          m_state;
    logic [31:0] m_q[$];
    logic [23:0] m_len;
    logic [23:0] m_played;
    logic [15:0] m_under;
    logic        m_ovf, m_pause, m_irq_en, m_irq;
    logic [31:0] m_sdata;
    logic        m_svalid;

    always #5 clk = ~clk;

    soc_system_play_ctrl dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .address      (address),
        .chipselect   (chipselect),
        .write_n      (write_n),
        .writedata    (writedata),
        .readdata     (readdata),
        .sample_tick  (sample_tick),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .playing      (playing),
        .irq          (irq)
    );

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic model_reset();
        m_state = 0; m_q.delete(); m_len = '0; m_played = '0; m_under = '0;
        m_ovf = 1'b0; m_pause = 1'b0; m_irq_en = 1'b0; m_irq = 1'b0;
        m_sdata = '0; m_svalid = 1'b0;
    endtask

    task automatic model_step(input logic cs_i, input logic wn_i, input logic [1:0] a_i,
                              input logic [31:0] wd_i, input logic tick_i);
        logic wr_en, ctrl, stop, completed, pre_ie;
        int   pre_state;
        wr_en = cs_i && !wn_i;
        ctrl  = wr_en && (a_i == 2'd0);
        stop  = ctrl && wd_i[2];
        pre_state = m_state;
        pre_ie    = m_irq_en;
        completed = 1'b0;
        m_svalid  = 1'b0;
        if (tick_i && pre_state == 1) begin
            m_svalid = 1'b1;
            if (m_q.size() > 0) begin
                m_sdata   = m_q.pop_front();
                m_played  = m_played + 24'd1;
                completed = (m_played == m_len);
            end else begin
                m_sdata = '0;
                if (m_under != 16'hFFFF) m_under = m_under + 16'd1;
            end
        end
        if (wr_en && a_i == 2'd3) begin
            if (m_q.size() < 8) m_q.push_back(wd_i);
            else m_ovf = 1'b1;
        end
        if (wr_en && a_i == 2'd1 && pre_state == 0) m_len = wd_i[23:0];
        if (ctrl) begin
            m_pause  = wd_i[1];
            m_irq_en = wd_i[3];
        end
        if (stop) begin
            m_state = 0; m_q.delete(); m_played = '0; m_under = '0; m_ovf = 1'b0; m_irq = 1'b0;
        end else if (completed) begin
            m_state = 3;
            if (pre_ie) m_irq = 1'b1;
        end else if (ctrl) begin
            if (pre_state == 0 && wd_i[0] && m_len != 0) begin
                m_state = 1; m_played = '0;
            end else if (pre_state == 1 && wd_i[1]) m_state = 2;
            else if (pre_state == 2 && !wd_i[1]) m_state = 1;
            else if (pre_state == 3) begin
                m_state = 0; m_irq = 1'b0;
            end
        end
    endtask

    function automatic logic [31:0] model_status();
        return {m_under, 7'd0, m_ovf, 4'(m_q.size()), (m_q.size() == 8),
                (m_q.size() == 0), 2'(m_state)};
    endfunction

    // One clock: drive at the negedge, DUT and model advance at posedge, return at next negedge.
    task automatic cycle(input logic cs_i, input logic wn_i, input logic [1:0] a_i,
                         input logic [31:0] wd_i, input logic tick_i);
        chipselect = cs_i; write_n = wn_i; address = a_i; writedata = wd_i; sample_tick = tick_i;
        @(posedge clk);
        model_step(cs_i, wn_i, a_i, wd_i, tick_i);
        @(negedge clk);
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0; sample_tick = 1'b0;
    endtask

    task automatic wr(input logic [1:0] a, input logic [31:0] d);
        cycle(1'b1, 1'b0, a, d, 1'b0);
    endtask

    task automatic tick();
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
    endtask

    task automatic rd(input logic [1:0] a, output logic [31:0] d);
        address = a; chipselect = 1'b1; write_n = 1'b1;
        #1;
        d = readdata;
        chipselect = 1'b0;
    endtask

    task automatic do_reset();
        chipselect = 1'b0; write_n = 1'b1; address = 2'd0; writedata = '0; sample_tick = 1'b0;
        reset_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
    endtask

    task automatic test_reset();
        logic [31:0] v;
        do_reset();
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%0h exp=0", sample_valid); end
        checks++; if (sample_data !== 32'd0) begin failures++; $display("FAIL reset_data got=%0h exp=0", sample_data); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL reset_playing got=%0h exp=0", playing); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL reset_irq got=%0h exp=0", irq); end
        rd(2'd2, v);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL reset_status got=%0h exp=4", v); end
        rd(2'd0, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_control got=%0h exp=0", v); end
        rd(2'd1, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_length got=%0h exp=0", v); end
        rd(2'd3, v);
        checks++; if (v !== 32'h0) begin failures++; $display("FAIL reset_played got=%0h exp=0", v); end
    endtask

    task automatic test_playback();
        logic [31:0] w[3];
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd3);
        for (int i = 0; i < 3; i++) begin
            w[i] = $urandom;
            wr(2'd3, w[i]);
        end
        wr(2'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL play_valid%0d got=%0h exp=1", i, sample_valid); end
            checks++; if (sample_data !== w[i]) begin failures++; $display("FAIL play_data%0d got=%0h exp=%0h", i, sample_data, w[i]); end
        end
        cycle(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL play_valid_end got=%0h exp=0", sample_valid); end
        rd(2'd2, v);
        checks++; if (v[1:0] !== 2'd3) begin failures++; $display("FAIL play_state_done got=%0h exp=3", v[1:0]); end
        rd(2'd3, v);
        checks++; if (v !== 32'd3) begin failures++; $display("FAIL play_played got=%0h exp=3", v); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL play_irq_masked got=%0h exp=0", irq); end
        wr(2'd0, 32'h0);
        rd(2'd2, v);
        checks++; if (v[1:0] !== 2'd0) begin failures++; $display("FAIL play_back_idle got=%0h exp=0", v[1:0]); end
    endtask

    task automatic test_underrun();
        logic [31:0] w, v;
        logic [31:0] exp_d[3];
        do_reset();
        w = $urandom;
        exp_d[0] = w; exp_d[1] = 32'd0; exp_d[2] = 32'd0;
        wr(2'd1, 32'd4);
        wr(2'd3, w);
        wr(2'd0, 32'h1);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL under_valid%0d got=%0h exp=1", i, sample_valid); end
            checks++; if (sample_data !== exp_d[i]) begin failures++; $display("FAIL under_data%0d got=%0h exp=%0h", i, sample_data, exp_d[i]); end
        end
        rd(2'd2, v);
        checks++; if (v[31:16] !== 16'd2) begin failures++; $display("FAIL under_count got=%0h exp=2", v[31:16]); end
        checks++; if (v[1:0] !== 2'd1) begin failures++; $display("FAIL under_state got=%0h exp=1", v[1:0]); end
        rd(2'd3, v);
        checks++; if (v !== 32'd1) begin failures++; $display("FAIL under_played got=%0h exp=1", v); end
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL under_playing got=%0h exp=1", playing); end
    endtask

    task automatic test_overflow();
        logic [31:0] v;
        do_reset();
        for (int i = 0; i < 9; i++) wr(2'd3, $urandom);
        rd(2'd2, v);
        checks++; if (v !== 32'h188) begin failures++; $display("FAIL ovf_status got=%0h exp=188", v); end
        wr(2'd0, 32'h4);
        rd(2'd2, v);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL ovf_after_stop got=%0h exp=4", v); end
    endtask

    task automatic test_pause();
        logic [31:0] p0, p1, v;
        do_reset();
        p0 = $urandom; p1 = $urandom;
        wr(2'd1, 32'd5);
        wr(2'd3, p0);
        wr(2'd3, p1);
        wr(2'd0, 32'h1);
        tick();
        checks++; if (sample_data !== p0) begin failures++; $display("FAIL pause_first got=%0h exp=%0h", sample_data, p0); end
        wr(2'd0, 32'h2);
        rd(2'd2, v);
        checks++; if (v[1:0] !== 2'd2) begin failures++; $display("FAIL pause_state got=%0h exp=2", v[1:0]); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL pause_playing got=%0h exp=0", playing); end
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL pause_valid%0d got=%0h exp=0", i, sample_valid); end
            checks++; if (sample_data !== p0) begin failures++; $display("FAIL pause_hold%0d got=%0h exp=%0h", i, sample_data, p0); end
        end
        wr(2'd0, 32'h0);
        checks++; if (playing !== 1'b1) begin failures++; $display("FAIL pause_resume got=%0h exp=1", playing); end
        tick();
        checks++; if (sample_valid !== 1'b1) begin failures++; $display("FAIL pause_next_valid got=%0h exp=1", sample_valid); end
        checks++; if (sample_data !== p1) begin failures++; $display("FAIL pause_next_data got=%0h exp=%0h", sample_data, p1); end
    endtask

    task automatic test_irq();
        logic [31:0] v;
        do_reset();
        wr(2'd0, 32'h8);
        rd(2'd0, v);
        checks++; if (v !== 32'h2) begin failures++; $display("FAIL irq_ctrl_read got=%0h exp=2", v); end
        wr(2'd1, 32'd1);
        wr(2'd3, $urandom);
        wr(2'd0, 32'h9);
        tick();
        checks++; if (irq !== 1'b1) begin failures++; $display("FAIL irq_set got=%0h exp=1", irq); end
        rd(2'd2, v);
        checks++; if (v[1:0] !== 2'd3) begin failures++; $display("FAIL irq_done_state got=%0h exp=3", v[1:0]); end
        wr(2'd0, 32'h8);
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL irq_clear got=%0h exp=0", irq); end
        rd(2'd2, v);
        checks++; if (v[1:0] !== 2'd0) begin failures++; $display("FAIL irq_idle got=%0h exp=0", v[1:0]); end
    endtask

    task automatic test_boundaries();
        logic [31:0] first, v;
        do_reset();
        wr(2'd0, 32'h1);
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL len0_play got=%0h exp=0", playing); end
        first = $urandom;
        wr(2'd3, first);
        tick();
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL idle_tick got=%0h exp=0", sample_valid); end
        rd(2'd2, v);
        checks++; if (v !== 32'h10) begin failures++; $display("FAIL idle_tick_level got=%0h exp=10", v); end
        wr(2'd1, 32'd20);
        for (int i = 0; i < 7; i++) wr(2'd3, $urandom);
        wr(2'd0, 32'h1);
        cycle(1'b1, 1'b0, 2'd3, $urandom, 1'b1);
        checks++; if (sample_data !== first) begin failures++; $display("FAIL full_pushpop_data got=%0h exp=%0h", sample_data, first); end
        rd(2'd2, v);
        checks++; if (v[8:2] !== 7'b0_1000_10) begin failures++; $display("FAIL full_pushpop_status got=%0h exp=22", v[8:2]); end
    endtask

    task automatic test_reset_mid_play();
        logic [31:0] v;
        do_reset();
        wr(2'd1, 32'd10);
        for (int i = 0; i < 7; i++) wr(2'd3, $urandom | 32'h1);
        wr(2'd0, 32'h1);
        tick();
        tick();
        rd(2'd2, v);
        checks++; if (v[7:4] !== 4'd5) begin failures++; $display("FAIL mid_level got=%0h exp=5", v[7:4]); end
        reset_n = 1'b0;
        #1;
        checks++; if (sample_data !== 32'd0) begin failures++; $display("FAIL mid_rst_data got=%0h exp=0", sample_data); end
        checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL mid_rst_valid got=%0h exp=0", sample_valid); end
        checks++; if (playing !== 1'b0) begin failures++; $display("FAIL mid_rst_playing got=%0h exp=0", playing); end
        checks++; if (irq !== 1'b0) begin failures++; $display("FAIL mid_rst_irq got=%0h exp=0", irq); end
        rd(2'd2, v);
        checks++; if (v !== 32'h4) begin failures++; $display("FAIL mid_rst_status got=%0h exp=4", v); end
        @(negedge clk);
        reset_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (sample_valid !== 1'b0) begin failures++; $display("FAIL mid_post_valid%0d got=%0h exp=0", i, sample_valid); end
        end
    endtask

    task automatic test_random();
        logic [31:0] v, wd;
        logic        tk, risky;
        int          r;
        do_reset();
        for (int n = 0; n < 600; n++) begin
            r  = $urandom_range(0, 99);
            tk = ($urandom_range(0, 2) == 0);
            risky = (m_state == 1) && (m_q.size() > 0) && (32'(m_played) + 1 == 32'(m_len));
            wd = 32'($urandom_range(0, 1)) << 3;
            if (r < 35)      cycle(1'b1, 1'b0, 2'd3, $urandom, tk);
            else if (r < 60) cycle(1'b0, 1'b1, 2'd0, 32'd0, 1'b1);
            else if (r < 66) cycle(1'b1, 1'b0, 2'd1, {8'($urandom), 24'($urandom_range(0, 5))}, tk);
            else if (r < 90) begin
                if (r < 74)      wd = wd | 32'h1;
                else if (r < 80) wd = wd | 32'h2;
                else if (r >= 86) wd = 32'h4 | 32'($urandom_range(0, 15));
                cycle(1'b1, 1'b0, 2'd0, wd, tk && !risky);
            end else cycle(1'b0, 1'b1, 2'd0, 32'd0, 1'b0);
            checks++; if (sample_valid !== m_svalid) begin failures++; $display("FAIL rnd_valid n=%0d got=%0h exp=%0h", n, sample_valid, m_svalid); end
            checks++; if (sample_data !== m_sdata) begin failures++; $display("FAIL rnd_data n=%0d got=%0h exp=%0h", n, sample_data, m_sdata); end
            checks++; if (playing !== (m_state == 1)) begin failures++; $display("FAIL rnd_playing n=%0d got=%0h exp=%0h", n, playing, m_state == 1); end
            checks++; if (irq !== (m_irq && m_irq_en)) begin failures++; $display("FAIL rnd_irq n=%0d got=%0h exp=%0h", n, irq, m_irq && m_irq_en); end
            rd(2'd2, v);
            checks++; if (v !== model_status()) begin failures++; $display("FAIL rnd_status n=%0d got=%0h exp=%0h", n, v, model_status()); end
            rd(2'd3, v);
            checks++; if (v !== {8'd0, m_played}) begin failures++; $display("FAIL rnd_played n=%0d got=%0h exp=%0h", n, v, m_played); end
            rd(2'd0, v);
            checks++; if (v !== {30'd0, m_irq_en, m_pause}) begin failures++; $display("FAIL rnd_control n=%0d got=%0h exp=%0h", n, v, {m_irq_en, m_pause}); end
        end
    endtask

    initial begin
        reset_n = 1'b0;
        model_reset();
        test_reset();
        test_playback();
        test_underrun();
        test_overflow();
        test_pause();
        test_irq();
        test_boundaries();
        test_reset_mid_play();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
